// File: rtl/vector_serializer_pkg.sv
// Shared definitions for the vector buffer / vector serializer pair.
// VEC_W is the vector width both blocks must agree on.
package vector_serializer_pkg;

   // Bits per vector exchanged between the buffer and the serializer.
   localparam int VEC_W = 8;

   // Serializer shifter states.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_e;

endpackage

// File: rtl/vector_serializer_skid_fifo.sv
// Small ring-buffer FIFO that decouples buffer responses from the shifter.
// Push and pop in the same cycle are both honoured; a push into a full
// FIFO is only accepted when a pop frees the slot in the same cycle.
// o_count_next exposes the post-edge occupancy so the parent can run its
// request credit check a cycle ahead.
module vector_serializer_skid_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2   // power of two, >= 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic [$clog2(DEPTH):0]   o_count_next,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!o_full || w_pop_ok);

   // Occupancy after this edge: unchanged when push and pop coincide.
   always_comb begin
      // NOTE: assign a default before any branch so the block never infers a latch.
      o_count_next = r_count;
      if (w_push_ok && !w_pop_ok) begin
         o_count_next = r_count + CNT_W'(1);
      end else if (!w_push_ok && w_pop_ok) begin
         o_count_next = r_count - CNT_W'(1);
      end
   end

   // Pointers and count; pointers are exactly PTR_W wide so they wrap for free.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= o_count_next;
      end
   end

   // Storage write port.
   always_ff @(posedge clk) begin
      // NOTE: the data array is not reset; the count alone marks which entries are live.
      if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/vector_serializer.sv
// Pulls vectors from the vector buffer with a registered req / next-cycle
// vec_valid handshake, parks them in a skid FIFO and shifts them out
// MSB-first with ready/valid flow control. out_last marks bit 0 of each
// vector so the sink can recover framing. A request is only issued when a
// FIFO slot is guaranteed for its response, so a full-FIFO push cannot occur.
module vector_serializer
   import vector_serializer_pkg::*;
#(
   parameter int WIDTH = VEC_W,
   parameter int DEPTH = 2   // power of two, >= 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] vector,
   input  logic             vec_valid,
   output logic             req,
   output logic             out_bit,
   output logic             out_valid,
   output logic             out_last,
   input  logic             out_ready,
   output logic             busy
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int BC_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // Request / response tracking.
   logic             r_req;
   logic             r_inflight;
   logic             w_req_nxt;
   logic             w_push;

   // FIFO interface.
   logic             w_pop;
   logic [WIDTH-1:0] w_head;
   logic [CNT_W-1:0] w_count;
   logic [CNT_W-1:0] w_count_next;
   logic             w_full;
   logic             w_empty;

   // Shifter.
   ser_state_e       r_state;
   ser_state_e       w_state_nxt;
   logic [WIDTH-1:0] r_sr;
   logic [WIDTH-1:0] w_sr_nxt;
   logic [BC_W-1:0]  r_bc;
   logic [BC_W-1:0]  w_bc_nxt;

   // A response is only meaningful on the cycle after our own request.
   assign w_push = r_inflight && vec_valid;

   // Credit check: slots already claimed after this edge plus the request
   // that becomes in flight must leave room for one more response.
   assign w_req_nxt = ({1'b0, w_count_next} + (CNT_W + 1)'(r_req)) < (CNT_W + 1)'(DEPTH);

   vector_serializer_skid_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_skid_fifo (
      .clk          (clk),
      .rst          (rst),
      .i_push       (w_push),
      .i_push_data  (vector),
      .i_pop        (w_pop),
      .o_head       (w_head),
      .o_count      (w_count),
      .o_count_next (w_count_next),
      .o_full       (w_full),
      .o_empty      (w_empty)
   );

   // Registered request and its one-cycle-delayed in-flight flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req      <= 1'b0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= r_req;
         r_req      <= w_req_nxt;
      end
   end

   // Shifter next-state: load from FIFO head, shift on accept, reload at bit 0.
   always_comb begin
      w_state_nxt = r_state;
      w_sr_nxt    = r_sr;
      w_bc_nxt    = r_bc;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_sr_nxt    = w_head;
               w_bc_nxt    = BC_W'(WIDTH - 1);
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (out_ready) begin
               if (r_bc == '0) begin
                  // Last bit accepted: chain the next vector with no bubble.
                  if (!w_empty) begin
                     w_pop    = 1'b1;
                     w_sr_nxt = w_head;
                     w_bc_nxt = BC_W'(WIDTH - 1);
                  end else begin
                     w_sr_nxt    = '0;
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_sr_nxt = {r_sr[WIDTH-2:0], 1'b0};
                  w_bc_nxt = r_bc - BC_W'(1);
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Shifter state register; reset discards any partially sent vector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_sr    <= '0;
         r_bc    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sr    <= w_sr_nxt;
         r_bc    <= w_bc_nxt;
      end
   end

   assign req       = r_req;
   assign out_valid = (r_state == SHIFT);
   assign out_bit   = out_valid && r_sr[WIDTH-1];
   assign out_last  = out_valid && (r_bc == '0);
   assign busy      = (w_count != '0) || out_valid || r_inflight;

   // The credit scheme must never let a response land on a full FIFO.
   a_no_overflow : assert property (@(posedge clk) disable iff (rst) w_push |-> !w_full);

   // The buffer must only answer requests we actually issued.
   a_no_orphan : assert property (@(posedge clk) disable iff (rst) vec_valid |-> r_inflight);

endmodule

// File: tb/tb_vector_serializer.sv
// Bench for vector_serializer: a buffer responder answers each req on the
// following cycle from a queue of vectors and appends their bits, MSB-first,
// to an expected-bit queue; a compare process checks every presented bit
// against that queue and logs accepted bits for the literal checks below.
module tb_vector_serializer;
   import vector_serializer_pkg::*;

   localparam int W = VEC_W;
   localparam int D = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] vector;
   logic         vec_valid;
   logic         req;
   logic         out_bit;
   logic         out_valid;
   logic         out_last;
   logic         out_ready;
   logic         busy;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] src_q[$];      // vectors the buffer will hand out
   bit           exp_bit[$];    // model: bits still owed to the sink
   bit           exp_last[$];
   bit           acc_bits[$];   // log of accepted bits
   bit           acc_last[$];
   int           acc_cyc[$];
   int           cyc             = 0;
   int           first_req_cyc   = -1;
   int           first_valid_cyc = -1;
   int           stall_cnt       = 0;
   bit           stall_or        = 1'b0;

   always #5 clk = ~clk;

   vector_serializer #(
      .WIDTH (W),
      .DEPTH (D)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .vector    (vector),
      .vec_valid (vec_valid),
      .req       (req),
      .out_bit   (out_bit),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy)
   );

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Pack the first n logged bits (or last flags) into an integer, first bit as MSB.
   function automatic int pack_log(input int n, input bit sel_last);
      int v = 0;
      for (int i = 0; i < n && i < acc_bits.size(); i++)
         v = (v << 1) | int'(sel_last ? acc_last[i] : acc_bits[i]);
      return v;
   endfunction

   task automatic clear_log();
      acc_bits.delete();
      acc_last.delete();
      acc_cyc.delete();
   endtask

   task automatic wait_acc(input int n, input int budget, input string name);
      int k = 0;
      while (acc_bits.size() < n && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      check(name, int'(acc_bits.size() >= n), 1);
   endtask

   // Buffer model: answer a request on the next cycle, with data if any is queued.
   initial begin : responder
      bit seen;
      vec_valid = 1'b0;
      vector    = '0;
      forever begin
         @(negedge clk);
         seen = req && !rst;
         @(posedge clk);
         #1;
         if (seen && !rst && src_q.size() != 0) begin
            vector    = src_q.pop_front();
            vec_valid = 1'b1;
            for (int i = W - 1; i >= 0; i--) begin
               exp_bit.push_back(vector[i]);
               exp_last.push_back(i == 0);
            end
         end else begin
            vec_valid = 1'b0;
            vector    = '0;
         end
      end
   end

   // Compare process: checks outputs every cycle, away from the rising edge.
   initial begin : compare
      bit p_valid;
      bit p_ready;
      bit p_bit;
      bit p_last;
      p_valid = 1'b0;
      p_ready = 1'b0;
      p_bit   = 1'b0;
      p_last  = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            check("rst_outputs", int'({req, out_valid, out_bit, out_last, busy}), 0);
            p_valid = 1'b0;
         end else begin
            if (first_req_cyc < 0 && req) first_req_cyc = cyc;
            if (p_valid && !p_ready)
               check("stall_hold", int'({out_valid, out_bit, out_last}), int'({1'b1, p_bit, p_last}));
            if (out_valid) begin
               if (first_valid_cyc < 0) first_valid_cyc = cyc;
               check("busy_when_valid", int'(busy), 1);
               check("exp_avail", int'(exp_bit.size() != 0), 1);
               if (exp_bit.size() != 0) begin
                  check("out_bit", int'(out_bit), int'(exp_bit[0]));
                  check("out_last", int'(out_last), int'(exp_last[0]));
                  if (out_ready) begin
                     void'(exp_bit.pop_front());
                     void'(exp_last.pop_front());
                     acc_bits.push_back(out_bit);
                     acc_last.push_back(out_last);
                     acc_cyc.push_back(cyc);
                  end else begin
                     stall_cnt++;
                     stall_or |= out_bit;
                  end
               end
            end
            p_valid = out_valid;
            p_ready = out_ready;
            p_bit   = out_bit;
            p_last  = out_last;
         end
      end
   end

   initial begin : main
      rst       = 1'b1;
      out_ready = 1'b1;

      // Single vector A5 straight out of reset.
      src_q.push_back(8'hA5);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      wait_acc(8, 60, "t1_done");
      check("t1_stream", pack_log(8, 1'b0), 'hA5);
      check("t1_last", pack_log(8, 1'b1), 'h01);
      check("t1_latency", first_valid_cyc - first_req_cyc, 3);
      check("t1_drained", exp_bit.size(), 0);

      // Back-to-back FF then 00 with no bubble.
      clear_log();
      src_q.push_back(8'hFF);
      src_q.push_back(8'h00);
      wait_acc(16, 80, "t2_done");
      check("t2_stream", pack_log(16, 1'b0), 'hFF00);
      check("t2_last", pack_log(16, 1'b1), 'h0101);
      if (acc_cyc.size() >= 16) check("t2_contiguous", acc_cyc[15] - acc_cyc[0], 15);

      // Backpressure: 81 with 3 stalled cycles after the first bit.
      clear_log();
      stall_cnt = 0;
      stall_or  = 1'b0;
      src_q.push_back(8'h81);
      wait_acc(1, 60, "t3_first");
      @(posedge clk);
      #1 out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b1;
      wait_acc(8, 60, "t3_done");
      check("t3_stream", pack_log(8, 1'b0), 'h81);
      check("t3_last", pack_log(8, 1'b1), 'h01);
      check("t3_stall_cycles", stall_cnt, 3);
      check("t3_stall_bit", int'(stall_or), 0);

      // Empty buffer: req every cycle, nothing shown.
      @(posedge clk);
      #1 out_ready = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         check("t4_empty_valid", int'(out_valid), 0);
         check("t4_empty_req", int'(req), 1);
      end

      // Three vectors with the sink stalled: FIFO full plus one in the shifter.
      clear_log();
      src_q.push_back(8'h12);
      src_q.push_back(8'h34);
      src_q.push_back(8'h56);
      repeat (12) @(negedge clk);
      #1;
      check("t4_all_taken", src_q.size(), 0);
      check("t4_valid_held", int'(out_valid), 1);
      check("t4_bit_held", int'(out_bit), 0);
      check("t4_busy", int'(busy), 1);
      check("t4_owed_bits", exp_bit.size(), 24);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         check("t4_full_req", int'(req), 0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_acc(24, 100, "t4_done");
      check("t4_stream", pack_log(24, 1'b0), 'h123456);

      // Reset during bit 4 of C3, then a fresh 3C.
      clear_log();
      src_q.push_back(8'hC3);
      wait_acc(3, 60, "t5_three");
      @(negedge clk);
      #2 rst = 1'b1;
      exp_bit.delete();
      exp_last.delete();
      check("t5_mid_vector", acc_bits.size(), 4);
      src_q.delete();
      src_q.push_back(8'h3C);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      clear_log();
      wait_acc(8, 60, "t5_done");
      check("t5_stream", pack_log(8, 1'b0), 'h3C);
      check("t5_last", pack_log(8, 1'b1), 'h01);
      repeat (6) @(negedge clk);
      #1;
      check("t5_no_residue", acc_bits.size(), 8);
      check("t5_idle", int'(out_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/vector_serializer.md
Name: vector_serializer

Overview:
- Downstream consumer of the 8-bit vector buffer: pulls vectors with a single-cycle req/valid handshake, holds them in a small skid FIFO and shifts them out MSB-first on a serial bit stream with ready/valid flow control.
- Marks the last bit of each vector, so the serial sink can recover vector framing.
- Sits between the vector buffer and the output pin logic.

Parameters:
- WIDTH, 8, bits per vector; must match the buffer vector width.
- DEPTH, 2, skid FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- vector  in  WIDTH  vector from the buffer; meaningful only when vec_valid=1
- vec_valid  in  1  buffer response: 1 = vector carries data; 0 = buffer was empty
- req  out  1  request one vector from the buffer
- out_bit  out  1  current serial bit
- out_valid  out  1  out_bit is valid
- out_last  out  1  out_bit is bit 0 (last bit) of its vector
- out_ready  in  1  sink accepts out_bit this cycle
- busy  out  1  FIFO non-empty, or shifter active, or request in flight

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - Reset is asynchronous and active-high on rst.
  - While rst=1, all state clears: req=0, out_valid=0, out_bit=0, out_last=0, busy=0, FIFO empty, inflight=0, FSM in IDLE.
- Buffer handshake:
  - req is a registered output. The buffer answers on the cycle after req=1 with vec_valid/vector. vec_valid=0 means no data; the request is consumed with no retry penalty.
  - inflight = req registered one cycle; at most one request is outstanding per cycle.
  - req(next) = !rst && (fifo_count + inflight_next < DEPTH). This guarantees every vec_valid=1 response has a free FIFO slot.
  - A response with vec_valid=1 arriving when the FIFO is full is a protocol violation; simulation asserts on it, and the RTL never causes it.
  - vec_valid=1 with inflight=0 is ignored (assertion flags it).
- FIFO:
  - Ring buffer of DEPTH × WIDTH.
  - Pointers are $clog2(DEPTH) bits, plus a count of $clog2(DEPTH)+1 bits.
  - Pointers wrap naturally.
  - A push and a pop in the same cycle are both honoured, and the count is unchanged.
- Shifter FSM:
  - IDLE: out_valid=0. If FIFO non-empty, pop the head into shift register sr, set bit counter bc=WIDTH-1, go to SHIFT.
  - SHIFT: out_valid=1, out_bit=sr[WIDTH-1], out_last=(bc==0).
    - On out_valid && out_ready: shift sr left by 1, decrement bc.
    - If bc==0 and the FIFO is non-empty: pop the next vector into sr in the same cycle, bc=WIDTH-1, stay in SHIFT. Zero-bubble back-to-back vectors.
    - If bc==0 and the FIFO is empty: go to IDLE.
  - If out_ready=0, out_bit, out_valid and out_last hold stable.
  - Latency: first out_valid appears 1 cycle after the FIFO becomes non-empty. From the first req to the first out_valid is 3 cycles when the buffer has data.
  - Sustained throughput: 1 bit/cycle while out_ready=1 and the buffer supplies one vector per WIDTH cycles.
- Boundaries:
  - Empty buffer: req keeps asserting each cycle. Nothing is pushed, and out_valid stays 0.
  - FIFO full: req drops, and reasserts on the cycle after a pop frees a slot and no request is in flight.
  - Reset mid-shift: the partially sent vector is discarded. After release, the first out_valid bit is the MSB of a freshly fetched vector.
  - Reset while a request is in flight: the response cycle is ignored, because inflight was cleared.

Decomposition:
- A shared package, used by the buffer too, holds:
  - VEC_W = 8
  - localparam for the FSM state enum {IDLE, SHIFT}
- One natural sub-module is skid_fifo: parameterized WIDTH/DEPTH ring FIFO with push, pop, count, full and empty.
- The serializer FSM, the request-credit logic and the shifter stay in vector_serializer.

Test Plan:
- Single vector: buffer returns 8'hA5 with vec_valid=1 after the first req, out_ready=1.
  - Serial stream is 1,0,1,0,0,1,0,1.
  - out_last=1 only on the 8th bit.
  - First out_valid occurs 3 cycles after the first req.
- Back-to-back: buffer supplies 8'hFF then 8'h00, out_ready=1.
  - 16 contiguous valid bits with no bubble: 8 ones then 8 zeros.
  - out_last pulses at bits 8 and 16.
- Backpressure: 8'h81 with out_ready low for 3 cycles after bit 1.
  - out_bit=0 holds stable with out_valid=1 through the stall.
  - The total sequence is still 1,0,0,0,0,0,0,1.
- Empty/full:
  - Buffer returns vec_valid=0 for 10 cycles: out_valid=0, req=1 each cycle.
  - Then 3 vectors arrive with out_ready=0: the FIFO fills to DEPTH=2 plus one vector in the shifter, and req deasserts.
  - No assertion fires.
- Reset mid-operation: assert rst during bit 4 of 8'hC3, release, buffer supplies 8'h3C.
  - All outputs are 0 during reset.
  - The next stream is 0,0,1,1,1,1,0,0, with no residue of 8'hC3.
